// File: rtl/ipsxe_floating_point_umadd_issue_v1_0_if.sv
// rtl/ipsxe_floating_point_umadd_issue_v1_0_if.sv - stream bundle between the umadd issuer and its neighbours
//
// Groups the signals around the multiply-add issuer:
//   i_axi4s_{a,b,c,d}_tdata, i_axi4s_tvalid, o_axi4s_tready : upstream operand tuple stream
//   o_core_{a,b,c,d}_tdata, o_core_tvalid                   : valid-only operand issue to the core
//   i_core_result_tdata, i_core_result_tvalid               : valid-only result stream from the core
//   o_axi4s_result_tdata/tvalid, i_axi4s_result_tready      : downstream result stream
//   o_overflow                                              : sticky result-drop flag
// slave is the issuer's view; master is the surrounding system's view.
interface ipsxe_floating_point_umadd_issue_v1_0_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_axi4s_a_tdata;
    logic [DATA_WIDTH-1:0] i_axi4s_b_tdata;
    logic [DATA_WIDTH-1:0] i_axi4s_c_tdata;
    logic [DATA_WIDTH-1:0] i_axi4s_d_tdata;
    logic                  i_axi4s_tvalid;
    logic                  o_axi4s_tready;
    logic [DATA_WIDTH-1:0] o_core_a_tdata;
    logic [DATA_WIDTH-1:0] o_core_b_tdata;
    logic [DATA_WIDTH-1:0] o_core_c_tdata;
    logic [DATA_WIDTH-1:0] o_core_d_tdata;
    logic                  o_core_tvalid;
    logic [DATA_WIDTH-1:0] i_core_result_tdata;
    logic                  i_core_result_tvalid;
    logic [DATA_WIDTH-1:0] o_axi4s_result_tdata;
    logic                  o_axi4s_result_tvalid;
    logic                  i_axi4s_result_tready;
    logic                  o_overflow;

    modport slave (
        input  i_axi4s_a_tdata, i_axi4s_b_tdata, i_axi4s_c_tdata, i_axi4s_d_tdata,
        input  i_axi4s_tvalid,
        output o_axi4s_tready,
        output o_core_a_tdata, o_core_b_tdata, o_core_c_tdata, o_core_d_tdata,
        output o_core_tvalid,
        input  i_core_result_tdata, i_core_result_tvalid,
        output o_axi4s_result_tdata, o_axi4s_result_tvalid,
        input  i_axi4s_result_tready,
        output o_overflow
    );

    modport master (
        output i_axi4s_a_tdata, i_axi4s_b_tdata, i_axi4s_c_tdata, i_axi4s_d_tdata,
        output i_axi4s_tvalid,
        input  o_axi4s_tready,
        input  o_core_a_tdata, o_core_b_tdata, o_core_c_tdata, o_core_d_tdata,
        input  o_core_tvalid,
        output i_core_result_tdata, i_core_result_tvalid,
        input  o_axi4s_result_tdata, o_axi4s_result_tvalid,
        output i_axi4s_result_tready,
        input  o_overflow
    );
endinterface

// File: rtl/ipsxe_floating_point_umadd_issue_v1_0.sv
// rtl/ipsxe_floating_point_umadd_issue_v1_0.sv - operand issuer and result collector for the p = a*c + b*d core
//
// Ports:
//   i_aclk      : clock
//   i_areset_n  : asynchronous active-low reset
//   i_aclken    : clock enable, low freezes every register and blocks both stream handshakes
//   bus         : operand, core and result streams (see the interface file)
// Every accepted tuple holds one credit until its result is popped downstream, so the
// result FIFO always has room for whatever the backpressure-less core returns.
module ipsxe_floating_point_umadd_issue_v1_0 #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic i_aclk,
    input  logic i_areset_n,
    input  logic i_aclken,
    ipsxe_floating_point_umadd_issue_v1_0_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  core_tvalid_q, core_tvalid_d;
    logic [DATA_WIDTH-1:0] core_a_q, core_a_d;
    logic [DATA_WIDTH-1:0] core_b_q, core_b_d;
    logic [DATA_WIDTH-1:0] core_c_q, core_c_d;
    logic [DATA_WIDTH-1:0] core_d_q, core_d_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic tready;
    logic result_tvalid;
    logic accept;
    logic pop;
    logic wr_req;
    logic full;
    logic wr_en;

    // Ready is derived from the credit register only; the reset term keeps it low while reset is held.
    assign tready        = i_areset_n & i_aclken & (cnt_q < DEPTH_C);
    assign result_tvalid = i_aclken & (occ_q != '0);
    assign accept        = bus.i_axi4s_tvalid & tready;
    assign pop           = result_tvalid & bus.i_axi4s_result_tready;
    assign wr_req        = i_aclken & bus.i_core_result_tvalid;
    assign full          = (occ_q == DEPTH_C);
    // A full FIFO can still take a result when the head leaves in the same cycle.
    assign wr_en         = wr_req & (~full | pop);

    always_comb begin
        cnt_d         = cnt_q;
        occ_d         = occ_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        overflow_d    = overflow_q;
        core_tvalid_d = core_tvalid_q;
        core_a_d      = core_a_q;
        core_b_d      = core_b_q;
        core_c_d      = core_c_q;
        core_d_d      = core_d_q;
        mem_d         = mem_q;

        if (i_aclken) begin
            core_tvalid_d = accept;
            if (accept) begin
                core_a_d = bus.i_axi4s_a_tdata;
                core_b_d = bus.i_axi4s_b_tdata;
                core_c_d = bus.i_axi4s_c_tdata;
                core_d_d = bus.i_axi4s_d_tdata;
            end

            case ({accept, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase

            if (wr_en) begin
                mem_d[wr_ptr_q] = bus.i_core_result_tdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({wr_en, pop})
                2'b10:   occ_d = occ_q + CNT_ONE;
                2'b01:   occ_d = occ_q - CNT_ONE;
                default: occ_d = occ_q;
            endcase

            if (wr_req & full & ~pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            cnt_q         <= '0;
            occ_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            core_tvalid_q <= 1'b0;
            core_a_q      <= '0;
            core_b_q      <= '0;
            core_c_q      <= '0;
            core_d_q      <= '0;
            mem_q         <= '{default: '0};
        end else begin
            cnt_q         <= cnt_d;
            occ_q         <= occ_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            core_tvalid_q <= core_tvalid_d;
            core_a_q      <= core_a_d;
            core_b_q      <= core_b_d;
            core_c_q      <= core_c_d;
            core_d_q      <= core_d_d;
            mem_q         <= mem_d;
        end
    end

    assign bus.o_axi4s_tready        = tready;
    assign bus.o_core_tvalid         = core_tvalid_q;
    assign bus.o_core_a_tdata        = core_a_q;
    assign bus.o_core_b_tdata        = core_b_q;
    assign bus.o_core_c_tdata        = core_c_q;
    assign bus.o_core_d_tdata        = core_d_q;
    assign bus.o_axi4s_result_tvalid = result_tvalid;
    assign bus.o_axi4s_result_tdata  = mem_q[rd_ptr_q];
    assign bus.o_overflow            = overflow_q;
endmodule

// File: tb/tb_ipsxe_floating_point_umadd_issue_v1_0.sv
// tb/tb_ipsxe_floating_point_umadd_issue_v1_0.sv - self-checking bench for the umadd issuer
module tb_ipsxe_floating_point_umadd_issue_v1_0;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 9;

    logic clk = 1'b0;
    logic rst_n;
    logic aclken;
    int   total = 0;
    int   bad = 0;
    int   model_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic          use_prog = 1'b0;
    logic [DW-1:0] prog_word = '0;
    logic          inj_v = 1'b0;
    logic [DW-1:0] inj_d = '0;
    logic [LAT-1:0] pipe_v;
    logic [DW-1:0]  pipe_d [LAT];

    always #5 clk = ~clk;

    ipsxe_floating_point_umadd_issue_v1_0_if #(.DATA_WIDTH(DW)) bus ();

    ipsxe_floating_point_umadd_issue_v1_0 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_aclk    (clk),
        .i_areset_n(rst_n),
        .i_aclken  (aclken),
        .bus       (bus)
    );

    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] a, b, c, d);
        return use_prog ? prog_word : (a * c + b * d);
    endfunction

    // Core stand-in: fixed-latency, no backpressure, frozen by the clock enable, shares reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int k = 0; k < LAT; k++) pipe_d[k] <= '0;
        end else if (aclken) begin
            pipe_v    <= {pipe_v[LAT-2:0], bus.o_core_tvalid};
            pipe_d[0] <= core_fn(bus.o_core_a_tdata, bus.o_core_b_tdata, bus.o_core_c_tdata, bus.o_core_d_tdata);
            for (int k = 1; k < LAT; k++) pipe_d[k] <= pipe_d[k-1];
        end
    end
    assign bus.i_core_result_tvalid = pipe_v[LAT-1] | inj_v;
    assign bus.i_core_result_tdata  = inj_v ? inj_d : pipe_d[LAT-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: record handshakes in the reference (credit count and in-order result queue).
    task automatic tick();
        logic acc, pp;
        #1;
        acc = bus.i_axi4s_tvalid & bus.o_axi4s_tready;
        pp  = bus.o_axi4s_result_tvalid & bus.i_axi4s_result_tready;
        if (acc) begin
            exp_q.push_back(core_fn(bus.i_axi4s_a_tdata, bus.i_axi4s_b_tdata, bus.i_axi4s_c_tdata, bus.i_axi4s_d_tdata));
            model_cnt++;
        end
        if (pp && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            model_cnt--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_tuple();
        bus.i_axi4s_a_tdata = $urandom;
        bus.i_axi4s_b_tdata = $urandom;
        bus.i_axi4s_c_tdata = $urandom;
        bus.i_axi4s_d_tdata = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        aclken = 1'b1;
        bus.i_axi4s_tvalid = 1'b0;
        bus.i_axi4s_result_tready = 1'b0;
        new_tuple();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.o_axi4s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", bus.o_axi4s_tready); end
        total++; if (bus.o_core_tvalid !== 1'b0) begin bad++; $display("FAIL reset_core_tvalid: got %b want 0", bus.o_core_tvalid); end
        total++; if (bus.o_axi4s_result_tvalid !== 1'b0) begin bad++; $display("FAIL reset_result_tvalid: got %b want 0", bus.o_axi4s_result_tvalid); end
        total++; if (bus.o_axi4s_result_tdata !== '0) begin bad++; $display("FAIL reset_result_tdata: got %h want 0", bus.o_axi4s_result_tdata); end
        total++; if ((bus.o_core_a_tdata | bus.o_core_b_tdata | bus.o_core_c_tdata | bus.o_core_d_tdata) !== '0) begin bad++; $display("FAIL reset_core_data: got nonzero operands"); end
        total++; if (bus.o_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", bus.o_overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.o_axi4s_tready !== 1'b1) begin bad++; $display("FAIL release_tready: got %b want 1", bus.o_axi4s_tready); end
        total++; if (bus.o_axi4s_result_tvalid !== 1'b0) begin bad++; $display("FAIL release_result_tvalid: got %b want 0", bus.o_axi4s_result_tvalid); end
    endtask

    task automatic test_single();
        int n;
        use_prog = 1'b1;
        prog_word = 32'h4130_0000;
        bus.i_axi4s_a_tdata = 32'h3F80_0000;
        bus.i_axi4s_b_tdata = 32'h4000_0000;
        bus.i_axi4s_c_tdata = 32'h4040_0000;
        bus.i_axi4s_d_tdata = 32'h4080_0000;
        bus.i_axi4s_tvalid = 1'b1;
        bus.i_axi4s_result_tready = 1'b1;
        tick();
        bus.i_axi4s_tvalid = 1'b0;
        total++; if (bus.o_core_tvalid !== 1'b1) begin bad++; $display("FAIL single_issue: got %b want 1", bus.o_core_tvalid); end
        total++; if ({bus.o_core_a_tdata, bus.o_core_b_tdata, bus.o_core_c_tdata, bus.o_core_d_tdata} !== 128'h3F800000_40000000_40400000_40800000) begin
            bad++; $display("FAIL single_operands: got %h %h %h %h", bus.o_core_a_tdata, bus.o_core_b_tdata, bus.o_core_c_tdata, bus.o_core_d_tdata);
        end
        tick();
        total++; if (bus.o_core_tvalid !== 1'b0) begin bad++; $display("FAIL single_issue_once: got %b want 0", bus.o_core_tvalid); end
        n = 2;
        while (!bus.o_axi4s_result_tvalid && n < 40) begin tick(); n++; end
        total++; if (n != 11) begin bad++; $display("FAIL single_latency: result at cycle %0d want 11", n); end
        total++; if (bus.o_axi4s_result_tdata !== 32'h4130_0000) begin bad++; $display("FAIL single_result: got %h want 41300000", bus.o_axi4s_result_tdata); end
        tick();
        total++; if (bus.o_axi4s_result_tvalid !== 1'b0) begin bad++; $display("FAIL single_pop_valid: got %b want 0", bus.o_axi4s_result_tvalid); end
        total++; if (bus.o_axi4s_tready !== 1'b1) begin bad++; $display("FAIL single_pop_credit: got %b want 1", bus.o_axi4s_tready); end
        use_prog = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nacc, npop;
        logic acc;
        nacc = 0; npop = 0;
        bus.i_axi4s_result_tready = 1'b0;
        new_tuple();
        bus.i_axi4s_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            total++; if (bus.o_axi4s_tready !== (model_cnt < DEPTH)) begin bad++; $display("FAIL b2b_fill_tready: got %b cnt %0d", bus.o_axi4s_tready, model_cnt); end
            acc = bus.i_axi4s_tvalid & bus.o_axi4s_tready;
            tick();
            if (acc) begin nacc++; if (nacc < 6) new_tuple(); else bus.i_axi4s_tvalid = 1'b0; end
        end
        total++; if (nacc != 4) begin bad++; $display("FAIL b2b_accepted: got %0d want 4", nacc); end
        total++; if (bus.o_axi4s_tready !== 1'b0) begin bad++; $display("FAIL b2b_stalled: got %b want 0", bus.o_axi4s_tready); end
        total++; if (bus.o_axi4s_result_tvalid !== 1'b1) begin bad++; $display("FAIL b2b_buffered: got %b want 1", bus.o_axi4s_result_tvalid); end
        bus.i_axi4s_result_tready = 1'b1;
        total++; if (bus.o_axi4s_tready !== 1'b0) begin bad++; $display("FAIL b2b_ready_on_pop: got %b want 0", bus.o_axi4s_tready); end
        npop++;
        total++; if (exp_q.size() == 0 || bus.o_axi4s_result_tdata !== exp_q[0]) begin bad++; $display("FAIL b2b_first_pop: got %h", bus.o_axi4s_result_tdata); end
        tick();
        total++; if (bus.o_axi4s_tready !== 1'b1) begin bad++; $display("FAIL b2b_release: got %b want 1", bus.o_axi4s_tready); end
        for (int i = 0; i < 60 && !(nacc == 6 && exp_q.size() == 0); i++) begin
            acc = bus.i_axi4s_tvalid & bus.o_axi4s_tready;
            if (bus.o_axi4s_result_tvalid) begin
                npop++; total++;
                if (exp_q.size() == 0 || bus.o_axi4s_result_tdata !== exp_q[0]) begin bad++; $display("FAIL b2b_order: got %h", bus.o_axi4s_result_tdata); end
            end
            tick();
            if (acc) begin nacc++; if (nacc < 6) new_tuple(); else bus.i_axi4s_tvalid = 1'b0; end
        end
        total++; if (npop != 6 || nacc != 6) begin bad++; $display("FAIL b2b_counts: popped %0d accepted %0d want 6 6", npop, nacc); end
    endtask

    task automatic test_simultaneous();
        int nacc, npop;
        logic acc;
        nacc = 0; npop = 0;
        bus.i_axi4s_result_tready = 1'b0;
        new_tuple();
        bus.i_axi4s_tvalid = 1'b1;
        for (int i = 0; i < 20 && nacc < 3; i++) begin
            acc = bus.i_axi4s_tvalid & bus.o_axi4s_tready;
            tick();
            if (acc) begin nacc++; new_tuple(); end
        end
        bus.i_axi4s_tvalid = 1'b0;
        repeat (14) tick();
        new_tuple();
        bus.i_axi4s_tvalid = 1'b1;
        bus.i_axi4s_result_tready = 1'b1;
        total++; if (bus.o_axi4s_tready !== 1'b1) begin bad++; $display("FAIL simul_ready_before: got %b want 1", bus.o_axi4s_tready); end
        total++; if (bus.o_axi4s_result_tvalid !== 1'b1 || exp_q.size() == 0 || bus.o_axi4s_result_tdata !== exp_q[0]) begin
            bad++; $display("FAIL simul_pop_data: valid %b data %h", bus.o_axi4s_result_tvalid, bus.o_axi4s_result_tdata);
        end
        tick();
        bus.i_axi4s_tvalid = 1'b0;
        bus.i_axi4s_result_tready = 1'b0;
        total++; if (bus.o_axi4s_tready !== 1'b1) begin bad++; $display("FAIL simul_ready_after: got %b want 1", bus.o_axi4s_tready); end
        new_tuple();
        bus.i_axi4s_tvalid = 1'b1;
        tick();
        bus.i_axi4s_tvalid = 1'b0;
        total++; if (bus.o_axi4s_tready !== 1'b0) begin bad++; $display("FAIL simul_cnt_full: got %b want 0", bus.o_axi4s_tready); end
        bus.i_axi4s_result_tready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            if (bus.o_axi4s_result_tvalid) begin
                npop++; total++;
                if (bus.o_axi4s_result_tdata !== exp_q[0]) begin bad++; $display("FAIL simul_order: got %h want %h", bus.o_axi4s_result_tdata, exp_q[0]); end
            end
            tick();
        end
        total++; if (npop != 4) begin bad++; $display("FAIL simul_count: popped %0d want 4", npop); end
        repeat (12) tick();
        total++; if (bus.o_axi4s_result_tvalid !== 1'b0) begin bad++; $display("FAIL simul_no_dup: got %b want 0", bus.o_axi4s_result_tvalid); end
    endtask

    task automatic test_overflow();
        int nacc, npop;
        logic acc;
        nacc = 0; npop = 0;
        bus.i_axi4s_result_tready = 1'b0;
        new_tuple();
        bus.i_axi4s_tvalid = 1'b1;
        for (int i = 0; i < 20 && nacc < 4; i++) begin
            acc = bus.i_axi4s_tvalid & bus.o_axi4s_tready;
            tick();
            if (acc) begin nacc++; new_tuple(); end
        end
        bus.i_axi4s_tvalid = 1'b0;
        repeat (14) tick();
        total++; if (bus.o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b want 0", bus.o_overflow); end
        inj_d = 32'hDEAD_BEEF;
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        total++; if (bus.o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.o_overflow); end
        repeat (3) tick();
        total++; if (bus.o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bus.o_overflow); end
        bus.i_axi4s_result_tready = 1'b1;
        for (int i = 0; i < 20 && bus.o_axi4s_result_tvalid; i++) begin
            npop++; total++;
            if (exp_q.size() == 0 || bus.o_axi4s_result_tdata !== exp_q[0]) begin bad++; $display("FAIL ovf_drain: got %h", bus.o_axi4s_result_tdata); end
            tick();
        end
        total++; if (npop != 4) begin bad++; $display("FAIL ovf_drain_count: popped %0d want 4", npop); end
        total++; if (bus.o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_after_drain: got %b want 1", bus.o_overflow); end
    endtask

    task automatic test_aclken();
        int nacc, npop;
        logic acc;
        nacc = 0; npop = 0;
        new_tuple();
        bus.i_axi4s_tvalid = 1'b1;
        for (int c = 0; c < 400 && !(nacc == 10 && exp_q.size() == 0); c++) begin
            aclken = !(c >= 14 && c < 17);
            bus.i_axi4s_result_tready = ($urandom_range(0, 3) != 0);
            #1;
            if (!aclken) begin
                total++; if (bus.o_axi4s_tready !== 1'b0 || bus.o_axi4s_result_tvalid !== 1'b0) begin
                    bad++; $display("FAIL clken_freeze: tready %b tvalid %b want 0 0", bus.o_axi4s_tready, bus.o_axi4s_result_tvalid);
                end
            end else begin
                total++; if (bus.o_axi4s_tready !== (model_cnt < DEPTH)) begin bad++; $display("FAIL clken_credit: got %b cnt %0d", bus.o_axi4s_tready, model_cnt); end
            end
            acc = bus.i_axi4s_tvalid & bus.o_axi4s_tready;
            if (bus.o_axi4s_result_tvalid && bus.i_axi4s_result_tready) begin
                npop++; total++;
                if (exp_q.size() == 0 || bus.o_axi4s_result_tdata !== exp_q[0]) begin bad++; $display("FAIL clken_order: got %h", bus.o_axi4s_result_tdata); end
            end
            tick();
            if (acc) begin nacc++; if (nacc < 10) new_tuple(); else bus.i_axi4s_tvalid = 1'b0; end
        end
        aclken = 1'b1;
        total++; if (npop != 10) begin bad++; $display("FAIL clken_count: popped %0d want 10", npop); end
    endtask

    task automatic test_reset_midstream();
        int nacc, npop;
        logic acc;
        nacc = 0; npop = 0;
        bus.i_axi4s_result_tready = 1'b0;
        new_tuple();
        bus.i_axi4s_tvalid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            acc = bus.i_axi4s_tvalid & bus.o_axi4s_tready;
            tick();
            if (acc) begin nacc++; if (nacc < 3) new_tuple(); else bus.i_axi4s_tvalid = 1'b0; end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.o_axi4s_tready !== 1'b0 || bus.o_axi4s_result_tvalid !== 1'b0 || bus.o_core_tvalid !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs: tready %b rvalid %b cvalid %b want 0 0 0", bus.o_axi4s_tready, bus.o_axi4s_result_tvalid, bus.o_core_tvalid);
        end
        total++; if (bus.o_overflow !== 1'b0 || bus.o_axi4s_result_tdata !== '0) begin bad++; $display("FAIL midrst_clear: ovf %b data %h", bus.o_overflow, bus.o_axi4s_result_tdata); end
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.o_axi4s_tready !== 1'b1 || bus.o_axi4s_result_tvalid !== 1'b0) begin
            bad++; $display("FAIL midrst_release: tready %b rvalid %b want 1 0", bus.o_axi4s_tready, bus.o_axi4s_result_tvalid);
        end
        new_tuple();
        bus.i_axi4s_tvalid = 1'b1;
        bus.i_axi4s_result_tready = 1'b1;
        tick();
        bus.i_axi4s_tvalid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.o_axi4s_result_tvalid) begin
                npop++; total++;
                if (exp_q.size() == 0 || bus.o_axi4s_result_tdata !== exp_q[0]) begin bad++; $display("FAIL midrst_result: got %h", bus.o_axi4s_result_tdata); end
            end
            tick();
        end
        total++; if (npop != 1) begin bad++; $display("FAIL midrst_count: popped %0d want 1", npop); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_simultaneous();
        test_overflow();
        test_aclken();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ipsxe_floating_point_umadd_issue_v1_0.md
Name: ipsxe_floating_point_umadd_issue_v1_0

Overview:
- Operand issuer and result collector for the floating-point multiply-add core (p = a*c + b*d).
- Upstream side: AXI4-Stream slave carrying the four-operand tuple, with tready backpressure.
- Core side: drives the core's valid-only operand interface and receives its valid-only result stream.
- Downstream side: buffers results in a FIFO and presents them on an AXI4-Stream master with tready.
- Credit counting guarantees the core, which has no backpressure, never delivers a result the FIFO cannot store.

Parameters:
- DATA_WIDTH, 32, width of each operand and of the result.
- FIFO_DEPTH, 8, number of result FIFO entries and maximum outstanding tuples; power of two, at least 2.

Ports:
- i_aclk  in  1  clock.
- i_areset_n  in  1  asynchronous active-low reset.
- i_aclken  in  1  clock enable; low freezes all state.
- i_axi4s_a_tdata  in  DATA_WIDTH  operand a.
- i_axi4s_b_tdata  in  DATA_WIDTH  operand b.
- i_axi4s_c_tdata  in  DATA_WIDTH  operand c.
- i_axi4s_d_tdata  in  DATA_WIDTH  operand d.
- i_axi4s_tvalid  in  1  operand tuple valid.
- o_axi4s_tready  out  1  tuple accepted when high with tvalid.
- o_core_a_tdata / o_core_b_tdata / o_core_c_tdata / o_core_d_tdata  out  DATA_WIDTH each  registered operands to core.
- o_core_tvalid  out  1  one-cycle issue strobe to core.
- i_core_result_tdata  in  DATA_WIDTH  core result.
- i_core_result_tvalid  in  1  core result strobe.
- o_axi4s_result_tdata  out  DATA_WIDTH  FIFO head.
- o_axi4s_result_tvalid  out  1  FIFO non-empty.
- i_axi4s_result_tready  in  1  downstream ready.
- o_overflow  out  1  sticky: core result arrived with FIFO full.

Behaviour:
- Reset (async, i_areset_n=0): all outputs 0. Pointers, occupancy, outstanding count cnt and o_overflow are cleared. The operand registers are also cleared. Reset mid-operation discards in-flight and buffered results; the core shares the same reset.
- accept = i_axi4s_tvalid & o_axi4s_tready.
- pop = o_axi4s_result_tvalid & i_axi4s_result_tready.
- All state updates occur only when i_aclken=1.
- o_axi4s_tready = i_aclken & (cnt < FIFO_DEPTH). It depends on registers only, with no combinational path from i_axi4s_result_tready. A full-credit stall therefore releases one cycle after the first pop.
- cnt, of width log2(FIFO_DEPTH)+1, counts tuples accepted but not yet popped:
  - +1 on accept only;
  - -1 on pop only;
  - unchanged on simultaneous accept and pop.
- Issue: on accept, the operands are registered into o_core_*_tdata, and o_core_tvalid=1 for exactly the next enabled cycle. Otherwise o_core_tvalid=0 and the data registers hold. Latency from accept edge to o_core_tvalid is 1 cycle.
- Collect: when i_core_result_tvalid=1, i_core_result_tdata is written at the write pointer.
  - Write pointer and occupancy increment, modulo FIFO_DEPTH.
  - If the FIFO is full and there is no same-cycle pop: the write is dropped, o_overflow is set and stays at 1 until reset, and FIFO contents are unchanged.
  - Write with a same-cycle pop while full: both are performed.
- Output: first-word-fall-through.
  - o_axi4s_result_tvalid = i_aclken & (occupancy != 0).
  - o_axi4s_result_tdata = mem[rd_ptr].
  - A result written at edge k is visible after edge k, i.e. 1 cycle after its i_core_result_tvalid.
  - On pop, rd_ptr increments and occupancy decrements.
  - Simultaneous write and pop leaves occupancy unchanged.
- Order: results leave in core-arrival order. Pointers wrap from FIFO_DEPTH-1 to 0.
- Under normal operation cnt >= occupancy + core in-flight, so o_overflow never asserts.
- i_aclken=0:
  - o_axi4s_tready=0 and o_axi4s_result_tvalid=0;
  - core strobes are ignored, because the core is also frozen;
  - all registers hold.

Test Plan (FIFO_DEPTH=4, core model = fixed 9-cycle delay returning a programmable word):
- Reset held, then released → all outputs 0, o_axi4s_tready=1 on first cycle after release, cnt=0.
- One tuple a=0x3F800000, b=0x40000000, c=0x40400000, d=0x40800000 accepted at cycle 0 → o_core_tvalid=1 at cycle 1 only with those operands. Core returns 0x41300000 at cycle 10 → o_axi4s_result_tvalid=1 with 0x41300000 at cycle 11. Pop with tready=1 → valid drops, cnt=0.
- i_axi4s_result_tready=0, 6 tuples offered back-to-back → exactly 4 accepted, o_axi4s_tready=0 after the 4th, cnt=4. Raise tready → 4 results in order. o_axi4s_tready=1 the cycle after the first pop; tuples 5–6 then accepted.
- cnt=3 with accept and pop in the same cycle → cnt stays 3, o_axi4s_tready stays 1, no result lost or duplicated.
- FIFO holds 4 results, tready=0, model injects an unsolicited result 0xDEADBEEF → o_overflow=1 and stays 1. Draining yields the original 4 words only.
- i_aclken=0 for 3 cycles mid-stream → tready and tvalid are 0, no counter or pointer change. Resume yields in-order results. Reset asserted mid-stream → all outputs 0 immediately, cnt=0, FIFO empty.
